// File: rtl/onchip_memory_dp.sv
// onchip_memory_dp: true-dual-port RAM with two Avalon-MM slave ports, pipelined reads and sticky out-of-range flags
module onchip_memory_dp #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = "",
    localparam int BE_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic [ADDR_WIDTH-1:0] s1_address,
    input  logic                  s1_chipselect,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [BE_WIDTH-1:0]   s1_byteenable,
    input  logic [DATA_WIDTH-1:0] s1_writedata,
    output logic                  s1_waitrequest,
    output logic [DATA_WIDTH-1:0] s1_readdata,
    output logic                  s1_readdatavalid,
    output logic                  s1_oor,
    input  logic [ADDR_WIDTH-1:0] s2_address,
    input  logic                  s2_chipselect,
    input  logic                  s2_read,
    input  logic                  s2_write,
    input  logic [BE_WIDTH-1:0]   s2_byteenable,
    input  logic [DATA_WIDTH-1:0] s2_writedata,
    output logic                  s2_waitrequest,
    output logic [DATA_WIDTH-1:0] s2_readdata,
    output logic                  s2_readdatavalid,
    output logic                  s2_oor
);
    // one past the last legal word address, widened so DEPTH == 2**ADDR_WIDTH fits
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // index 0 is s1, index 1 is s2
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [BE_WIDTH-1:0]   be    [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [DATA_WIDTH-1:0] rdata [2];
    logic [1:0] cs, rd, wr, in_range, acc_rd, acc_wr, acc_oor, wr_en, rvalid, oor_q;

    assign addr[0]  = s1_address;
    assign addr[1]  = s2_address;
    assign be[0]    = s1_byteenable;
    assign be[1]    = s2_byteenable;
    assign wdata[0] = s1_writedata;
    assign wdata[1] = s2_writedata;
    assign cs       = {s2_chipselect, s1_chipselect};
    assign rd       = {s2_read, s1_read};
    assign wr       = {s2_write, s1_write};

    // a write on a port suppresses its read; clken gates every accept
    assign acc_wr  = {2{clken}} & cs & wr;
    assign acc_rd  = {2{clken}} & cs & rd & ~wr;
    assign acc_oor = {2{clken}} & cs & (rd | wr) & ~in_range;
    assign wr_en   = acc_wr & in_range;

    assign s1_waitrequest   = ~clken;
    assign s2_waitrequest   = ~clken;
    assign s1_readdata      = rdata[0];
    assign s2_readdata      = rdata[1];
    assign s1_readdatavalid = rvalid[0];
    assign s2_readdatavalid = rvalid[1];
    assign s1_oor           = oor_q[0];
    assign s2_oor           = oor_q[1];

    // byte-lane writes; s1 is applied last so it owns lanes both ports enable on the same word
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (wr_en[1] && be[1][b]) mem[addr[1]][b*8 +: 8] <= wdata[1][b*8 +: 8];
            if (wr_en[0] && be[0][b]) mem[addr[0]][b*8 +: 8] <= wdata[0][b*8 +: 8];
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  v1, oor_r;
        logic [DATA_WIDTH-1:0] d1;

        assign in_range[p] = {1'b0, addr[p]} < LIMIT;
        assign oor_q[p]    = oor_r;

        // first read stage: registered array output, old data on a same-cycle write, zero when out of range
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v1 <= 1'b0;
                d1 <= '0;
            end else if (clken) begin
                v1 <= acc_rd[p];
                if (acc_rd[p]) d1 <= in_range[p] ? mem[addr[p]] : '0;
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic                  v2;
            logic [DATA_WIDTH-1:0] d2;

            // second read stage: output register, data held between valid pulses
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else if (clken) begin
                    v2 <= v1;
                    if (v1) d2 <= d1;
                end
            end

            assign rvalid[p] = v2;
            assign rdata[p]  = d2;
        end else begin : g_lat1
            assign rvalid[p] = v1;
            assign rdata[p]  = d1;
        end

        // sticky out-of-range flag, cleared only by reset
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) oor_r <= 1'b0;
            else if (acc_oor[p]) oor_r <= 1'b1;
        end
    end
endmodule

// File: tb/tb_onchip_memory_dp.sv
// tb_onchip_memory_dp: drives a LAT=1 and a LAT=2 build in parallel and checks both against a queue-based memory model
module tb_onchip_memory_dp;
    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        clken = 1'b1;
    logic        cs [2], rd [2], wr [2];
    logic [9:0]  ad [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];

    // first index: 0 = LAT1 build, 1 = LAT2 build; second index: port
    logic        wq [2][2], vq [2][2], oq [2][2];
    logic [31:0] rq [2][2];

    // reference model
    logic [31:0] mm [1000];
    rd_t         q [2][2][$];
    logic        ev [2][2];
    logic [31:0] ed [2][2];
    logic        oor_m [2];
    int          en_cnt = 0;
    bit          last_en;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        onchip_memory_dp #(
            .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000), .READ_LATENCY(d + 1)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .clken(clken),
            .s1_address(ad[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
            .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_waitrequest(wq[d][0]),
            .s1_readdata(rq[d][0]), .s1_readdatavalid(vq[d][0]), .s1_oor(oq[d][0]),
            .s2_address(ad[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
            .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_waitrequest(wq[d][1]),
            .s2_readdata(rq[d][1]), .s2_readdatavalid(vq[d][1]), .s2_oor(oq[d][1])
        );
    end

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
            ad[p] = '0; be[p] = '0; wd[p] = '0;
        end
    endtask

    task automatic req(input int p, input bit r, input bit w, input int a, input logic [3:0] b, input logic [31:0] d);
        cs[p] = 1'b1; rd[p] = r; wr[p] = w; ad[p] = 10'(a); be[p] = b; wd[p] = d;
    endtask

    // one clock: model absorbs the edge, then expected outputs are derived at the falling edge
    task automatic tick();
        rd_t e;
        @(posedge clk);
        if (!reset_n) begin
            for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) q[d][p].delete();
            oor_m[0] = 1'b0; oor_m[1] = 1'b0;
        end else if (clken) begin
            en_cnt++;
            for (int p = 0; p < 2; p++) begin
                if (cs[p] && rd[p] && !wr[p]) begin
                    for (int d = 0; d < 2; d++) begin
                        e.data = (ad[p] < 10'd1000) ? mm[ad[p]] : 32'h0;
                        e.due  = en_cnt + d;
                        q[d][p].push_back(e);
                    end
                end
                if (cs[p] && (rd[p] || wr[p]) && ad[p] >= 10'd1000) oor_m[p] = 1'b1;
            end
            for (int p = 1; p >= 0; p--)
                if (cs[p] && wr[p] && ad[p] < 10'd1000)
                    for (int b = 0; b < 4; b++)
                        if (be[p][b]) mm[ad[p]][b*8 +: 8] = wd[p][b*8 +: 8];
        end
        last_en = reset_n && clken;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (!reset_n) begin
                    ev[d][p] = 1'b0; ed[d][p] = '0;
                end else if (last_en) begin
                    ev[d][p] = q[d][p].size() > 0 && q[d][p][0].due == en_cnt;
                    if (ev[d][p]) begin
                        ed[d][p] = q[d][p][0].data;
                        void'(q[d][p].pop_front());
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        idle();
        #2 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                checks++; if (vq[d][p] !== 1'b0) begin errors++; $display("FAIL rst_valid d%0d p%0d got %b want 0", d, p, vq[d][p]); end
                checks++; if (rq[d][p] !== 32'h0) begin errors++; $display("FAIL rst_data d%0d p%0d got %h want 0", d, p, rq[d][p]); end
                checks++; if (oq[d][p] !== 1'b0) begin errors++; $display("FAIL rst_oor d%0d p%0d got %b want 0", d, p, oq[d][p]); end
                checks++; if (wq[d][p] !== 1'b0) begin errors++; $display("FAIL rst_wait d%0d p%0d got %b want 0", d, p, wq[d][p]); end
            end
        end
        @(negedge clk);
        tick();
        reset_n = 1'b1;
        req(0, 1, 0, 3, 4'h0, 32'h0);
        tick();
        idle();
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (vq[d][0] !== 1'b0) begin errors++; $display("FAIL midrd_valid d%0d got %b want 0", d, vq[d][0]); end
            checks++; if (rq[d][0] !== 32'h0) begin errors++; $display("FAIL midrd_data d%0d got %h want 0", d, rq[d][0]); end
        end
        tick();
        reset_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++; if (vq[1][0] !== 1'b0) begin errors++; $display("FAIL dropped_valid cyc%0d got %b want 0", n, vq[1][0]); end
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 500; i++) begin
            req(0, 0, 1, 2 * i, 4'hF, $urandom);
            req(1, 0, 1, 2 * i + 1, 4'hF, $urandom);
            tick();
        end
        idle();
    endtask

    task automatic test_latency();
        logic [31:0] old6;
        idle(); req(0, 0, 1, 5, 4'hF, 32'hDEADBEEF); tick();
        old6 = mm[6];
        idle(); req(0, 1, 0, 5, 4'h0, 32'h0); tick();
        checks++; if (vq[0][0] !== 1'b1 || rq[0][0] !== 32'hDEADBEEF) begin errors++; $display("FAIL lat1_first got v=%b d=%h want v=1 d=deadbeef", vq[0][0], rq[0][0]); end
        checks++; if (vq[1][0] !== 1'b0) begin errors++; $display("FAIL lat2_early got %b want 0", vq[1][0]); end
        idle(); req(0, 1, 0, 6, 4'h0, 32'h0); tick();
        checks++; if (vq[0][0] !== 1'b1 || rq[0][0] !== old6) begin errors++; $display("FAIL lat1_second got v=%b d=%h want v=1 d=%h", vq[0][0], rq[0][0], old6); end
        checks++; if (vq[1][0] !== 1'b1 || rq[1][0] !== 32'hDEADBEEF) begin errors++; $display("FAIL lat2_first got v=%b d=%h want v=1 d=deadbeef", vq[1][0], rq[1][0]); end
        idle(); tick();
        checks++; if (vq[0][0] !== 1'b0) begin errors++; $display("FAIL lat1_end got %b want 0", vq[0][0]); end
        checks++; if (vq[1][0] !== 1'b1 || rq[1][0] !== old6) begin errors++; $display("FAIL lat2_second got v=%b d=%h want v=1 d=%h", vq[1][0], rq[1][0], old6); end
        tick();
        checks++; if (vq[1][0] !== 1'b0) begin errors++; $display("FAIL lat2_end got %b want 0", vq[1][0]); end
    endtask

    task automatic test_collision();
        idle(); req(0, 0, 1, 16, 4'hF, 32'h0); tick();
        idle(); req(0, 0, 1, 16, 4'b0011, 32'h11223344); req(1, 0, 1, 16, 4'b0110, 32'hAABBCCDD); tick();
        idle(); req(1, 1, 0, 16, 4'h0, 32'h0); tick();
        checks++; if (vq[0][1] !== 1'b1 || rq[0][1] !== 32'h00BB3344) begin errors++; $display("FAIL coll_lat1 got v=%b d=%h want v=1 d=00bb3344", vq[0][1], rq[0][1]); end
        idle(); tick();
        checks++; if (vq[1][1] !== 1'b1 || rq[1][1] !== 32'h00BB3344) begin errors++; $display("FAIL coll_lat2 got v=%b d=%h want v=1 d=00bb3344", vq[1][1], rq[1][1]); end
        tick();
    endtask

    task automatic test_rdw();
        idle(); req(1, 0, 1, 32, 4'hF, 32'h1); tick();
        idle(); req(0, 0, 1, 32, 4'hF, 32'h2); req(1, 1, 0, 32, 4'h0, 32'h0); tick();
        checks++; if (vq[0][1] !== 1'b1 || rq[0][1] !== 32'h1) begin errors++; $display("FAIL rdw_old got v=%b d=%h want v=1 d=1", vq[0][1], rq[0][1]); end
        checks++; if (vq[0][0] !== 1'b0) begin errors++; $display("FAIL rdw_wr_novalid got %b want 0", vq[0][0]); end
        idle(); req(1, 1, 0, 32, 4'h0, 32'h0); tick();
        checks++; if (vq[0][1] !== 1'b1 || rq[0][1] !== 32'h2) begin errors++; $display("FAIL rdw_new got v=%b d=%h want v=1 d=2", vq[0][1], rq[0][1]); end
        checks++; if (vq[1][1] !== 1'b1 || rq[1][1] !== 32'h1) begin errors++; $display("FAIL rdw_old_lat2 got v=%b d=%h want v=1 d=1", vq[1][1], rq[1][1]); end
        idle(); req(0, 1, 1, 48, 4'hF, 32'hCAFE); tick();
        checks++; if (vq[0][0] !== 1'b0) begin errors++; $display("FAIL rw_both_lat1 got %b want 0", vq[0][0]); end
        idle(); req(0, 1, 0, 48, 4'h0, 32'h0); tick();
        checks++; if (vq[1][0] !== 1'b0) begin errors++; $display("FAIL rw_both_lat2 got %b want 0", vq[1][0]); end
        checks++; if (vq[0][0] !== 1'b1 || rq[0][0] !== 32'hCAFE) begin errors++; $display("FAIL rw_both_wrote got v=%b d=%h want v=1 d=cafe", vq[0][0], rq[0][0]); end
        idle(); tick(); tick();
    endtask

    task automatic test_clken();
        logic [31:0] old40;
        idle(); req(0, 1, 0, 5, 4'h0, 32'h0); tick();
        old40 = mm[64];
        idle(); clken = 1'b0; req(1, 0, 1, 64, 4'hF, 32'h77);
        for (int n = 0; n < 3; n++) begin
            tick();
            for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) begin
                checks++; if (wq[d][p] !== 1'b1) begin errors++; $display("FAIL stall_wait cyc%0d d%0d p%0d got %b want 1", n, d, p, wq[d][p]); end
            end
            checks++; if (vq[1][0] !== 1'b0) begin errors++; $display("FAIL stall_lat2 cyc%0d got %b want 0", n, vq[1][0]); end
            checks++; if (vq[0][0] !== 1'b1 || rq[0][0] !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_hold cyc%0d got v=%b d=%h want v=1 d=deadbeef", n, vq[0][0], rq[0][0]); end
        end
        clken = 1'b1; idle(); tick();
        checks++; if (wq[1][0] !== 1'b0) begin errors++; $display("FAIL resume_wait got %b want 0", wq[1][0]); end
        checks++; if (vq[1][0] !== 1'b1 || rq[1][0] !== 32'hDEADBEEF) begin errors++; $display("FAIL resume_lat2 got v=%b d=%h want v=1 d=deadbeef", vq[1][0], rq[1][0]); end
        checks++; if (vq[0][0] !== 1'b0) begin errors++; $display("FAIL resume_lat1 got %b want 0", vq[0][0]); end
        idle(); req(1, 1, 0, 64, 4'h0, 32'h0); tick();
        checks++; if (vq[0][1] !== 1'b1 || rq[0][1] !== old40) begin errors++; $display("FAIL stall_noaccept got v=%b d=%h want v=1 d=%h", vq[0][1], rq[0][1], old40); end
        idle(); tick(); tick();
    endtask

    task automatic test_oor();
        logic [31:0] old999;
        old999 = mm[999];
        idle(); req(0, 0, 1, 1000, 4'hF, 32'h5); tick();
        for (int d = 0; d < 2; d++) begin
            checks++; if (oq[d][0] !== 1'b1) begin errors++; $display("FAIL oor_set d%0d got %b want 1", d, oq[d][0]); end
            checks++; if (oq[d][1] !== 1'b0) begin errors++; $display("FAIL oor_other d%0d got %b want 0", d, oq[d][1]); end
        end
        idle(); req(0, 1, 0, 1000, 4'h0, 32'h0); tick();
        checks++; if (vq[0][0] !== 1'b1 || rq[0][0] !== 32'h0) begin errors++; $display("FAIL oor_rd_lat1 got v=%b d=%h want v=1 d=0", vq[0][0], rq[0][0]); end
        idle(); req(1, 1, 0, 999, 4'h0, 32'h0); tick();
        checks++; if (vq[1][0] !== 1'b1 || rq[1][0] !== 32'h0) begin errors++; $display("FAIL oor_rd_lat2 got v=%b d=%h want v=1 d=0", vq[1][0], rq[1][0]); end
        checks++; if (vq[0][1] !== 1'b1 || rq[0][1] !== old999) begin errors++; $display("FAIL oor_999 got v=%b d=%h want v=1 d=%h", vq[0][1], rq[0][1], old999); end
        idle(); tick(); tick();
        checks++; if (oq[1][0] !== 1'b1) begin errors++; $display("FAIL oor_sticky got %b want 1", oq[1][0]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            clken = ($urandom % 6) != 0;
            for (int p = 0; p < 2; p++) begin
                cs[p] = ($urandom % 4) != 0;
                rd[p] = 1'($urandom_range(1));
                wr[p] = ($urandom % 3) == 0;
                ad[p] = (($urandom % 8) == 0) ? 10'(1000 + $urandom % 24) : 10'($urandom % 16);
                be[p] = 4'($urandom);
                wd[p] = $urandom;
            end
            tick();
            for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) begin
                checks++; if (vq[d][p] !== ev[d][p]) begin errors++; $display("FAIL rnd_valid n%0d d%0d p%0d got %b want %b", n, d, p, vq[d][p], ev[d][p]); end
                if (ev[d][p]) begin
                    checks++; if (rq[d][p] !== ed[d][p]) begin errors++; $display("FAIL rnd_data n%0d d%0d p%0d got %h want %h", n, d, p, rq[d][p], ed[d][p]); end
                end
                checks++; if (oq[d][p] !== oor_m[p]) begin errors++; $display("FAIL rnd_oor n%0d d%0d p%0d got %b want %b", n, d, p, oq[d][p], oor_m[p]); end
                checks++; if (wq[d][p] !== !clken) begin errors++; $display("FAIL rnd_wait n%0d d%0d p%0d got %b want %b", n, d, p, wq[d][p], !clken); end
            end
        end
        clken = 1'b1; idle(); tick(); tick();
    endtask

    task automatic test_reset_clears_oor();
        idle();
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) begin
            checks++; if (oq[d][p] !== 1'b0) begin errors++; $display("FAIL oor_clear d%0d p%0d got %b want 0", d, p, oq[d][p]); end
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        preload();
        test_latency();
        test_collision();
        test_rdw();
        test_clken();
        test_oor();
        test_random();
        test_reset_clears_oor();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
